ucsbece154b_branch_resolve: RTL and testbench

Execute-stage branch resolution unit directly downstream of ucsbece154b_branch. Carries fetch-time prediction metadata (taken, target, PHT index) through the D and E pipeline registers. Compares it with the actual outcome in E, raising a same-cycle mispredict redirect. Produces the registered BTB/PHT/GHR update strobes that feed back into the predictor's write ports.

---
 rtl/ucsbece154b_branch_resolve_pkg.sv | 19 +
 rtl/ucsbece154b_branch_resolve_bpmeta_reg.sv | 40 ++++
 rtl/ucsbece154b_branch_resolve.sv | 159 +++++++++++++++
 tb/tb_ucsbece154b_branch_resolve.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_branch_resolve_pkg.sv
// Shared opcode constants and metadata layout for the execute-stage branch resolver.
package ucsbece154b_branch_resolve_pkg;

  localparam logic [6:0] instr_branch_op = 7'b1100011;
  localparam logic [6:0] instr_jal_op    = 7'b1101111;
  localparam logic [6:0] instr_jalr_op   = 7'b1100111;

  // Metadata record = {valid, predtaken, predtarget[31:0], phtaddr}
  localparam int unsigned META_FIXED_W = 34;

  function automatic int unsigned meta_width(input int unsigned ghr_bits);
    return META_FIXED_W + ghr_bits;
  endfunction

  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == instr_branch_op) || (op == instr_jal_op) || (op == instr_jalr_op);
  endfunction

endpackage

// File: rtl/ucsbece154b_branch_resolve_bpmeta_reg.sv
// Prediction-metadata pipeline register: async reset, flush to zero, optional stall hold.
module ucsbece154b_bpmeta_reg #(
  parameter int unsigned W        = 39,
  parameter bit          STALL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         stall_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] meta_d;
  logic         hold_c;

  assign hold_c = STALL_EN & stall_i;

  // Flush wins over stall, stall wins over load
  always_comb begin
    meta_d = d_i;
    if (flush_i) begin
      meta_d = '0;
    end else if (hold_c) begin
      meta_d = meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= '0;
    end else begin
      meta_q <= meta_d;
    end
  end

  assign q_o = meta_q;

endmodule

// File: rtl/ucsbece154b_branch_resolve.sv
// Execute-stage branch resolution: mispredict redirect plus registered BTB/PHT/GHR updates.
// Optional BRANCH_STATS_EN adds branch and mispredict counters.
module ucsbece154b_branch_resolve
  import ucsbece154b_branch_resolve_pkg::*;
#(
  parameter int unsigned NUM_BTB_ENTRIES = 32,
  parameter int unsigned NUM_GHR_BITS    = 5
) (
  input  logic                               clk,
  input  logic                               reset_i,
  input  logic                               predtaken_f_i,
  input  logic [31:0]                        predtarget_f_i,
  input  logic [NUM_GHR_BITS-1:0]            phtaddr_f_i,
  input  logic                               stall_d_i,
  input  logic                               flush_d_i,
  input  logic                               flush_e_i,
  input  logic [6:0]                         op_e_i,
  input  logic [31:0]                        pc_e_i,
  input  logic [31:0]                        pcplus4_e_i,
  input  logic [31:0]                        target_e_i,
  input  logic                               taken_e_i,
  output logic                               mispredict_o,
  output logic [31:0]                        pcredirect_o,
  output logic                               BTB_we_o,
  output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
  output logic [31:0]                        BTBwritedata_o,
  output logic                               PHTwe_o,
  output logic                               PHTincrement_o,
  output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
  output logic                               GHRreset_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]                        stat_branches_o,
  output logic [31:0]                        stat_mispredicts_o
`endif
);

  localparam int unsigned BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);
  localparam int unsigned META_W    = meta_width(NUM_GHR_BITS);

  logic [META_W-1:0]       meta_f_c;
  logic [META_W-1:0]       meta_d_q;
  logic [META_W-1:0]       meta_e_q;
  logic                    valid_e;
  logic                    predtaken_e;
  logic [31:0]             predtarget_e;
  logic [NUM_GHR_BITS-1:0] phtaddr_e;
  logic                    ctrl_e_c;
  logic                    target_miss_c;
  logic                    unused_pc_bits_c;

  assign meta_f_c = {1'b1, predtaken_f_i, predtarget_f_i, phtaddr_f_i};

  ucsbece154b_bpmeta_reg #(.W(META_W), .STALL_EN(1'b1)) u_meta_d (
    .clk     (clk),
    .reset_i (reset_i),
    .flush_i (flush_d_i),
    .stall_i (stall_d_i),
    .d_i     (meta_f_c),
    .q_o     (meta_d_q)
  );

  ucsbece154b_bpmeta_reg #(.W(META_W), .STALL_EN(1'b0)) u_meta_e (
    .clk     (clk),
    .reset_i (reset_i),
    .flush_i (flush_e_i),
    .stall_i (1'b0),
    .d_i     (meta_d_q),
    .q_o     (meta_e_q)
  );

  assign {valid_e, predtaken_e, predtarget_e, phtaddr_e} = meta_e_q;

  assign ctrl_e_c      = valid_e & is_ctrl_op(op_e_i);
  assign target_miss_c = predtarget_e != target_e_i;

  // Non-control instructions predicted taken are BTB aliases and must redirect to PC+4
  always_comb begin
    mispredict_o = 1'b0;
    pcredirect_o = pcplus4_e_i;
    if (ctrl_e_c) begin
      mispredict_o = (taken_e_i != predtaken_e) | (taken_e_i & target_miss_c);
      if (taken_e_i) begin
        pcredirect_o = target_e_i;
      end
    end else if (valid_e) begin
      mispredict_o = predtaken_e;
    end
  end

  logic                    btb_we_d,   btb_we_q;
  logic [BTB_IDX_W-1:0]    btb_addr_d, btb_addr_q;
  logic [31:0]             btb_data_d, btb_data_q;
  logic                    pht_we_d,   pht_we_q;
  logic                    pht_inc_d,  pht_inc_q;
  logic [NUM_GHR_BITS-1:0] pht_addr_d, pht_addr_q;
  logic                    ghr_rst_d,  ghr_rst_q;

  assign btb_we_d   = ctrl_e_c & taken_e_i & (~predtaken_e | target_miss_c);
  assign btb_addr_d = pc_e_i[BTB_IDX_W+1:2];
  assign btb_data_d = target_e_i;
  assign pht_we_d   = valid_e & (op_e_i == instr_branch_op);
  assign pht_inc_d  = taken_e_i;
  assign pht_addr_d = phtaddr_e;
  assign ghr_rst_d  = mispredict_o;

  assign unused_pc_bits_c = ^{pc_e_i[31:BTB_IDX_W+2], pc_e_i[1:0]};

  // Update register loads every cycle; strobes land one cycle after resolution
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      btb_we_q   <= 1'b0;
      btb_addr_q <= '0;
      btb_data_q <= '0;
      pht_we_q   <= 1'b0;
      pht_inc_q  <= 1'b0;
      pht_addr_q <= '0;
      ghr_rst_q  <= 1'b0;
    end else begin
      btb_we_q   <= btb_we_d;
      btb_addr_q <= btb_addr_d;
      btb_data_q <= btb_data_d;
      pht_we_q   <= pht_we_d;
      pht_inc_q  <= pht_inc_d;
      pht_addr_q <= pht_addr_d;
      ghr_rst_q  <= ghr_rst_d;
    end
  end

  assign BTB_we_o          = btb_we_q;
  assign BTBwriteaddress_o = btb_addr_q;
  assign BTBwritedata_o    = btb_data_q;
  assign PHTwe_o           = pht_we_q;
  assign PHTincrement_o    = pht_inc_q;
  assign PHTwriteaddress_o = pht_addr_q;
  assign GHRreset_o        = ghr_rst_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  assign stat_br_d = stat_br_q + 32'(ctrl_e_c);
  assign stat_mp_d = stat_mp_q + 32'(mispredict_o);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Self-checking bench for ucsbece154b_branch_resolve: directed plan steps then randomized traffic.
module tb_ucsbece154b_branch_resolve;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;

  typedef struct packed {
    logic        v;
    logic        pt;
    logic [31:0] tgt;
    logic [4:0]  pht;
  } meta_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        predtaken_f_i;
  logic [31:0] predtarget_f_i;
  logic [4:0]  phtaddr_f_i;
  logic        stall_d_i, flush_d_i, flush_e_i;
  logic [6:0]  op_e_i;
  logic [31:0] pc_e_i, pcplus4_e_i, target_e_i;
  logic        taken_e_i;
  logic        mispredict_o;
  logic [31:0] pcredirect_o;
  logic        BTB_we_o;
  logic [4:0]  BTBwriteaddress_o;
  logic [31:0] BTBwritedata_o;
  logic        PHTwe_o, PHTincrement_o;
  logic [4:0]  PHTwriteaddress_o;
  logic        GHRreset_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_o, stat_mispredicts_o;
`endif

  ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .predtaken_f_i     (predtaken_f_i),
    .predtarget_f_i    (predtarget_f_i),
    .phtaddr_f_i       (phtaddr_f_i),
    .stall_d_i         (stall_d_i),
    .flush_d_i         (flush_d_i),
    .flush_e_i         (flush_e_i),
    .op_e_i            (op_e_i),
    .pc_e_i            (pc_e_i),
    .pcplus4_e_i       (pcplus4_e_i),
    .target_e_i        (target_e_i),
    .taken_e_i         (taken_e_i),
    .mispredict_o      (mispredict_o),
    .pcredirect_o      (pcredirect_o),
    .BTB_we_o          (BTB_we_o),
    .BTBwriteaddress_o (BTBwriteaddress_o),
    .BTBwritedata_o    (BTBwritedata_o),
    .PHTwe_o           (PHTwe_o),
    .PHTincrement_o    (PHTincrement_o),
    .PHTwriteaddress_o (PHTwriteaddress_o),
    .GHRreset_o        (GHRreset_o)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches_o    (stat_branches_o),
    .stat_mispredicts_o (stat_mispredicts_o)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: metadata seen by D and E, and the expected registered updates
  meta_t       md, me;
  logic        x_btb_we, x_pht_we, x_pht_inc, x_ghr;
  logic [4:0]  x_btb_addr, x_pht_addr;
  logic [31:0] x_btb_data;
  logic [31:0] x_stat_b, x_stat_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_ctrl();
    return me.v && (op_e_i == OP_BR || op_e_i == OP_JAL || op_e_i == OP_JALR);
  endfunction

  function automatic logic ref_mispredict();
    logic c;
    c = ref_ctrl();
    if (!me.v) return 1'b0;
    if (c && (taken_e_i != me.pt)) return 1'b1;
    if (c && taken_e_i && (me.tgt != target_e_i)) return 1'b1;
    if (!c && me.pt) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_redirect();
    return (ref_ctrl() && taken_e_i) ? target_e_i : pcplus4_e_i;
  endfunction

  task automatic model_clear();
    md = '0; me = '0;
    x_btb_we = 0; x_pht_we = 0; x_pht_inc = 0; x_ghr = 0;
    x_btb_addr = '0; x_pht_addr = '0; x_btb_data = '0;
    x_stat_b = '0; x_stat_m = '0;
  endtask

  task automatic check_outputs();
    chk("mispredict", 32'(mispredict_o), 32'(ref_mispredict()));
    chk("pcredirect", pcredirect_o, ref_redirect());
    chk("btb_we", 32'(BTB_we_o), 32'(x_btb_we));
    chk("btb_addr", 32'(BTBwriteaddress_o), 32'(x_btb_addr));
    chk("btb_data", BTBwritedata_o, x_btb_data);
    chk("pht_we", 32'(PHTwe_o), 32'(x_pht_we));
    chk("pht_inc", 32'(PHTincrement_o), 32'(x_pht_inc));
    chk("pht_addr", 32'(PHTwriteaddress_o), 32'(x_pht_addr));
    chk("ghr_reset", 32'(GHRreset_o), 32'(x_ghr));
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches_o, x_stat_b);
    chk("stat_mispredicts", stat_mispredicts_o, x_stat_m);
`endif
  endtask

  // Check current cycle, advance model and DUT by one clock, return at posedge+1
  task automatic tick();
    meta_t nmd, nme;
    logic nb, np, ni, ng, mp, c;
    logic [4:0] nba, npa;
    logic [31:0] nbd, nsb, nsm;
    #1;
    check_outputs();
    c  = ref_ctrl();
    mp = ref_mispredict();
    if (flush_d_i)      nmd = '0;
    else if (stall_d_i) nmd = md;
    else                nmd = '{v: 1'b1, pt: predtaken_f_i, tgt: predtarget_f_i, pht: phtaddr_f_i};
    nme = flush_e_i ? '0 : md;
    nb  = c && taken_e_i && (!me.pt || me.tgt != target_e_i);
    nba = pc_e_i[6:2];
    nbd = target_e_i;
    np  = me.v && (op_e_i == OP_BR);
    ni  = taken_e_i;
    npa = me.pht;
    ng  = mp;
    nsb = x_stat_b + (c ? 32'd1 : 32'd0);
    nsm = x_stat_m + (mp ? 32'd1 : 32'd0);
    @(posedge clk);
    if (reset_i) begin
      model_clear();
    end else begin
      md = nmd; me = nme;
      x_btb_we = nb; x_btb_addr = nba; x_btb_data = nbd;
      x_pht_we = np; x_pht_inc = ni; x_pht_addr = npa; x_ghr = ng;
      x_stat_b = nsb; x_stat_m = nsm;
    end
    #1;
  endtask

  task automatic drive_f(input logic pt, input logic [31:0] tgt, input logic [4:0] pht);
    predtaken_f_i = pt; predtarget_f_i = tgt; phtaddr_f_i = pht;
  endtask

  task automatic drive_e(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk);
    op_e_i = op; pc_e_i = pc; pcplus4_e_i = pc + 32'd4; target_e_i = tgt; taken_e_i = tk;
  endtask

  initial begin
    logic [31:0] pool [4];
    reset_i = 1'b1;
    stall_d_i = 0; flush_d_i = 0; flush_e_i = 0;
    drive_f(1'b0, 32'h0, 5'd0);
    drive_e(OP_ADD, 32'h0, 32'h0, 1'b0);
    model_clear();
    #2;
    check_outputs();
    tick();
    tick();
    reset_i = 1'b0;

    // Correctly predicted not-taken branch
    drive_f(1'b0, 32'h0, 5'd7);
    tick(); tick();
    drive_e(OP_BR, 32'h10, 32'h50, 1'b0);
    #1 chk("nt_mispredict", 32'(mispredict_o), 32'd0);
    tick();
    chk("nt_pht_we", 32'(PHTwe_o), 32'd1);
    chk("nt_pht_inc", 32'(PHTincrement_o), 32'd0);
    chk("nt_btb_we", 32'(BTB_we_o), 32'd0);
    chk("nt_pht_addr", 32'(PHTwriteaddress_o), 32'd7);

    // Missed taken branch
    drive_f(1'b0, 32'h0, 5'd3);
    drive_e(OP_ADD, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    drive_e(OP_BR, 32'h40, 32'h80, 1'b1);
    #1 chk("mt_mispredict", 32'(mispredict_o), 32'd1);
    chk("mt_redirect", pcredirect_o, 32'h80);
    tick();
    chk("mt_btb_we", 32'(BTB_we_o), 32'd1);
    chk("mt_btb_addr", 32'(BTBwriteaddress_o), 32'd16);
    chk("mt_btb_data", BTBwritedata_o, 32'h80);
    chk("mt_ghr", 32'(GHRreset_o), 32'd1);

    // Wrong jalr target
    drive_f(1'b1, 32'h100, 5'd9);
    drive_e(OP_ADD, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    drive_e(OP_JALR, 32'h20, 32'h104, 1'b1);
    #1 chk("jr_mispredict", 32'(mispredict_o), 32'd1);
    chk("jr_redirect", pcredirect_o, 32'h104);
    tick();
    chk("jr_btb_we", 32'(BTB_we_o), 32'd1);
    chk("jr_pht_we", 32'(PHTwe_o), 32'd0);

    // BTB alias: predicted taken on a plain add
    drive_f(1'b1, 32'h300, 5'd1);
    drive_e(OP_ADD, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    drive_e(OP_ADD, 32'h20, 32'h0, 1'b0);
    #1 chk("al_mispredict", 32'(mispredict_o), 32'd1);
    chk("al_redirect", pcredirect_o, 32'h24);
    tick();
    chk("al_btb_we", 32'(BTB_we_o), 32'd0);
    chk("al_pht_we", 32'(PHTwe_o), 32'd0);

    // Stall D for 3 cycles while E is flushed, then release
    drive_e(OP_ADD, 32'h0, 32'h0, 1'b0);
    drive_f(1'b1, 32'h444, 5'd21);
    tick();
    drive_f(1'b0, 32'h0, 5'd2);
    stall_d_i = 1; flush_e_i = 1;
    tick(); tick(); tick();
    stall_d_i = 0; flush_e_i = 0;
    tick();
    drive_e(OP_BR, 32'h8, 32'h444, 1'b1);
    #1 chk("st_mispredict", 32'(mispredict_o), 32'd0);
    tick();
    chk("st_pht_addr", 32'(PHTwriteaddress_o), 32'd21);

    // flush_d and stall_d together clear D
    drive_f(1'b1, 32'h500, 5'd4);
    drive_e(OP_ADD, 32'h0, 32'h0, 1'b0);
    flush_d_i = 1; stall_d_i = 1;
    tick();
    flush_d_i = 0; stall_d_i = 0;
    drive_f(1'b0, 32'h0, 5'd0);
    tick();
    drive_e(OP_BR, 32'h30, 32'h500, 1'b1);
    #1 chk("fd_mispredict", 32'(mispredict_o), 32'd0);
    tick();
    chk("fd_pht_we", 32'(PHTwe_o), 32'd0);
    chk("fd_btb_we", 32'(BTB_we_o), 32'd0);

    // Async reset mid-cycle with a mispredict resolving in E
    drive_f(1'b1, 32'h600, 5'd5);
    drive_e(OP_ADD, 32'h0, 32'h0, 1'b0);
    tick(); tick(); tick();
    drive_e(OP_LW, 32'h60, 32'h0, 1'b0);
    #1 chk("rs_pre_mispredict", 32'(mispredict_o), 32'd1);
    reset_i = 1;
    #1;
    model_clear();
    chk("rs_mispredict", 32'(mispredict_o), 32'd0);
    chk("rs_ghr", 32'(GHRreset_o), 32'd0);
    check_outputs();
    tick();
    reset_i = 0;

    // Randomized traffic
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h2000; pool[3] = 32'h0;
    for (int i = 0; i < 600; i++) begin
      logic [6:0] op;
      int sel;
      sel = int'($urandom_range(0, 4));
      op = (sel == 0) ? OP_BR : (sel == 1) ? OP_JAL : (sel == 2) ? OP_JALR :
           (sel == 3) ? OP_ADD : 7'($urandom);
      drive_f(1'($urandom), pool[$urandom_range(0, 3)], 5'($urandom));
      drive_e(op, $urandom & 32'hFFFF_FFFC, pool[$urandom_range(0, 3)],
              (op == OP_JAL || op == OP_JALR) ? 1'b1 : 1'($urandom));
      stall_d_i = ($urandom_range(0, 7) == 0);
      flush_d_i = ($urandom_range(0, 9) == 0);
      flush_e_i = ($urandom_range(0, 9) == 0);
      tick();
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
